// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Definitions shared between the pipeline output buffer and the issuing
// logic that consumes its credits.
//   cnt_w(depth)  : width of an occupancy / credit counter able to hold 0..depth
//   ptr_w(depth)  : width of a buffer index, at least 1 bit
//   ERR_*         : bit positions of the sticky error flags in a packed vector
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int ERR_OVF    = 0;  // word arrived while the buffer was full
   localparam int ERR_CREDIT = 1;  // issue attempted without a free credit
   localparam int ERR_UNEXP  = 2;  // word arrived with no credit in flight
   localparam int ERR_W      = 3;

   // Width of credit_t / count_t style counters for a given depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a buffer index; a single-entry buffer still gets one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// ---------------------------------------------------------------------------
// sync_fifo_core
// Storage half of the credit buffer: entry array, read/write pointers and
// occupancy count. Pushes into a full buffer and pops from an empty one are
// ignored here; the parent decides what that means.
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   push_i, wr_data_i  write request and data
//   pop_i              read request (advance head)
//   rd_data_o          head entry
//   count_o            stored entries, 0..DEPTH
//   full_o, empty_o    occupancy flags decoded from count
// ---------------------------------------------------------------------------
module sync_fifo_core
   import pipe_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic [cnt_w(DEPTH)-1:0]  count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);

   // A full buffer drops the push even when a pop frees a slot this cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i  & ~empty_o;

   // NOTE: every always_comb output gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the entry array is deliberately not reset; count gates validity, so stale contents are never exposed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/pipe_credit_buffer.sv
// ---------------------------------------------------------------------------
// pipe_credit_buffer
// Output-side elastic buffer for a fixed-latency, non-stallable pipeline.
// Words leaving the pipeline are captured unconditionally and offered on a
// valid/ready interface. A credit counter guarantees every launched word has
// a slot when it arrives: credit_ok is high while stored + in-flight words
// are below DEPTH.
// Ports:
//   clk, nrst                     clock, asynchronous active-low reset
//   issue / credit_ok             upstream launch strobe / launch permitted
//   in_valid, in_data             word exiting the pipeline (cannot stall)
//   out_valid, out_data, out_ready head entry handshake
//   count                         stored entries
//   err_clear                     synchronous clear of the sticky flags
//   err_ovf, err_credit, err_unexp sticky error flags
// ---------------------------------------------------------------------------
module pipe_credit_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     issue,
   output logic                     credit_ok,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [cnt_w(DEPTH)-1:0]  count,
   input  logic                     err_clear,
   output logic                     err_ovf,
   output logic                     err_credit,
   output logic                     err_unexp
);

   localparam int CW = cnt_w(DEPTH);

   logic [CW-1:0]    inflight_q, inflight_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [CW:0]      committed;
   logic             full, empty, acc_issue;

   sync_fifo_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push_i    (in_valid),
      .wr_data_i (in_data),
      .pop_i     (out_ready),
      .rd_data_o (out_data),
      .count_o   (count),
      .full_o    (full),
      .empty_o   (empty)
   );

   // Credits depend only on registered state, so issue never loops back
   // combinationally into credit_ok. One extra bit: unexpected arrivals can
   // push the sum past DEPTH.
   assign committed = {1'b0, count} + {1'b0, inflight_q};
   assign credit_ok = (committed < (CW + 1)'(DEPTH));
   assign acc_issue = issue & credit_ok;
   assign out_valid = ~empty;

   always_comb begin
      inflight_d = inflight_q;
      // An issue and an arrival in the same cycle cancel out. An arrival with
      // nothing in flight is flagged below and must not wrap the counter.
      if (acc_issue && !in_valid)
         inflight_d = inflight_q + CW'(1);
      else if (!acc_issue && in_valid && (inflight_q != '0))
         inflight_d = inflight_q - CW'(1);
   end

   always_comb begin
      // Clear first, then OR in new events: a same-cycle error wins.
      err_d = err_clear ? '0 : err_q;
      if (in_valid && full)                err_d[ERR_OVF]    = 1'b1;
      if (issue && !credit_ok)             err_d[ERR_CREDIT] = 1'b1;
      if (in_valid && (inflight_q == '0))  err_d[ERR_UNEXP]  = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         inflight_q <= '0;
         err_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign err_ovf    = err_q[ERR_OVF];
   assign err_credit = err_q[ERR_CREDIT];
   assign err_unexp  = err_q[ERR_UNEXP];

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_credit_buffer
// Three buffer instances (DEPTH 4, 8, 5), each fed by its own 4-cycle delay
// chain that carries only accepted issues. Shared stimulus drives all three;
// each directed step checks the instance it targets.
// Index 0: DEPTH=4, index 1: DEPTH=8, index 2: DEPTH=5.
// ---------------------------------------------------------------------------
module tb_pipe_credit_buffer;

   logic       clk = 1'b0;
   logic       nrst;
   logic       want, force_issue, inj_v, out_ready, err_clear;
   logic [7:0] idata, inj_d;

   logic             eff_issue [3];
   logic             in_valid  [3];
   logic [7:0]       in_data   [3];
   logic             cok       [3];
   logic             ov        [3];
   logic [7:0]       od        [3];
   logic             eovf      [3];
   logic             ecr       [3];
   logic             eun       [3];
   logic [3:0]       pv        [3];
   logic [3:0][7:0]  pd        [3];
   logic [2:0]       cnt_a, cnt_c;
   logic [3:0]       cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Issuing logic launches only with a credit unless a violation is forced.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         eff_issue[i] = want & (cok[i] | force_issue);
         in_valid[i]  = pv[i][3] | inj_v;
         in_data[i]   = inj_v ? inj_d : pd[i][3];
      end
   end

   // Latency-4 delay chains sharing the buffer reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < 3; i++) pv[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            pv[i] <= {pv[i][2:0], eff_issue[i] & cok[i]};
            pd[i] <= {pd[i][2:0], idata};
         end
      end
   end

   pipe_credit_buffer #(.DATA_W(8), .DEPTH(4)) u_a (
      .clk(clk), .nrst(nrst), .issue(eff_issue[0]), .credit_ok(cok[0]),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .out_valid(ov[0]),
      .out_data(od[0]), .out_ready(out_ready), .count(cnt_a),
      .err_clear(err_clear), .err_ovf(eovf[0]), .err_credit(ecr[0]), .err_unexp(eun[0]));

   pipe_credit_buffer #(.DATA_W(8), .DEPTH(8)) u_b (
      .clk(clk), .nrst(nrst), .issue(eff_issue[1]), .credit_ok(cok[1]),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .out_valid(ov[1]),
      .out_data(od[1]), .out_ready(out_ready), .count(cnt_b),
      .err_clear(err_clear), .err_ovf(eovf[1]), .err_credit(ecr[1]), .err_unexp(eun[1]));

   pipe_credit_buffer #(.DATA_W(8), .DEPTH(5)) u_c (
      .clk(clk), .nrst(nrst), .issue(eff_issue[2]), .credit_ok(cok[2]),
      .in_valid(in_valid[2]), .in_data(in_data[2]), .out_valid(ov[2]),
      .out_data(od[2]), .out_ready(out_ready), .count(cnt_c),
      .err_clear(err_clear), .err_ovf(eovf[2]), .err_credit(ecr[2]), .err_unexp(eun[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, credit, unexp} for one instance.
   function automatic logic [2:0] errs(input int i);
      return {eovf[i], ecr[i], eun[i]};
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      nrst = 1'b0;
      #2;
      nrst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_q [$];
      logic [7:0] exp_w;
      int issued, popped;

      nrst = 1'b0; want = 1'b0; force_issue = 1'b0; inj_v = 1'b0; inj_d = '0;
      idata = '0; out_ready = 1'b0; err_clear = 1'b0;

      // ---- reset state
      #2;
      for (int i = 0; i < 3; i++) begin
         check("reset_out_valid", ov[i], 0);
         check("reset_credit_ok", cok[i], 1);
         check("reset_errs", errs(i), 3'b000);
      end
      check("reset_count_a", cnt_a, 0);
      check("reset_count_b", cnt_b, 0);
      tick();
      nrst = 1'b1;

      // ---- credit exhaustion, DEPTH=4: issue held, only 4 accepted
      for (int k = 0; k < 8; k++) begin
         want  = 1'b1;
         idata = 8'hA0 + 8'(k);
         tick();
         check("exhaust_credit_ok", cok[0], (k < 3) ? 1 : 0);
      end
      check("exhaust_count", cnt_a, 4);
      check("exhaust_out_valid", ov[0], 1);
      check("exhaust_head", od[0], 8'hA0);
      check("exhaust_errs", errs(0), 3'b000);

      // ---- credit return: one pop frees one credit next cycle
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("return_count", cnt_a, 3);
      check("return_head", od[0], 8'hA1);
      check("return_credit_ok", cok[0], 1);
      idata = 8'hB0;
      tick();
      want = 1'b0;
      check("return_credit_spent", cok[0], 0);
      check("return_count_hold", cnt_a, 3);
      for (int k = 0; k < 4; k++) tick();
      check("return_refill", cnt_a, 4);
      check("return_errs", errs(0), 3'b000);

      // ---- overflow: push into full buffer (also unexpected: nothing in flight)
      inj_d = 8'hEE; inj_v = 1'b1;
      tick();
      inj_v = 1'b0;
      check("ovf_errs", errs(0), 3'b101);
      check("ovf_count", cnt_a, 4);
      check("ovf_head", od[0], 8'hA1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("clear_errs", errs(0), 3'b000);

      // ---- forced issue without credit
      force_issue = 1'b1; want = 1'b1;
      tick();
      force_issue = 1'b0; want = 1'b0;
      check("credit_err", errs(0), 3'b010);
      check("credit_err_ok", cok[0], 0);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;

      // ---- drain in order; overflowed word must not appear
      exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
      out_ready = 1'b1;
      foreach (exp_q[j]) begin
         check("drain_data", od[0], exp_q[j]);
         tick();
      end
      out_ready = 1'b0;
      check("drain_empty", ov[0], 0);
      check("drain_credit_ok", cok[0], 1);

      // ---- unexpected word: flagged, stored, inflight not wrapped
      inj_d = 8'h5A; inj_v = 1'b1;
      tick();
      inj_v = 1'b0;
      check("unexp_errs", errs(0), 3'b001);
      check("unexp_count", cnt_a, 1);
      check("unexp_data", od[0], 8'h5A);
      check("unexp_credit_ok", cok[0], 1);

      // ---- clear colliding with a new error: flag stays set
      err_clear = 1'b1; inj_d = 8'h5B; inj_v = 1'b1;
      tick();
      inj_v = 1'b0;
      check("clear_vs_err", errs(0), 3'b001);
      check("clear_vs_err_count", cnt_a, 2);
      tick();
      err_clear = 1'b0;
      check("clear_final", errs(0), 3'b000);

      // ---- streaming, DEPTH=8, ready held high
      pulse_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 72; k++) begin
         want  = (k < 64);
         idata = 8'(k);
         tick();
         check("stream_valid", ov[1], (k >= 4 && k <= 67) ? 1 : 0);
         if (k >= 4 && k <= 67) check("stream_data", od[1], 32'(k - 4));
      end
      want = 1'b0;
      check("stream_errs", errs(1), 3'b000);
      check("stream_count", cnt_b, 0);

      // ---- wrap-around, DEPTH=5, random backpressure, 200 words
      pulse_reset();
      exp_q = {};
      issued = 0;
      popped = 0;
      for (int cyc = 0; cyc < 4000 && popped < 200; cyc++) begin
         out_ready = ($urandom_range(0, 2) == 0);
         want      = (issued < 200);
         idata     = issued[7:0];
         if (want && cok[2]) begin
            exp_q.push_back(idata);
            issued++;
         end
         if (ov[2] && out_ready) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check("wrap_data", od[2], exp_w);
            popped++;
         end
         tick();
      end
      want = 1'b0; out_ready = 1'b0;
      check("wrap_popped", popped, 200);
      check("wrap_count", cnt_c, 0);
      check("wrap_errs", errs(2), 3'b000);

      // ---- mid-traffic reset on DEPTH=8: count=3, inflight=2
      pulse_reset();
      for (int k = 0; k < 7; k++) begin
         want  = (k < 5);
         idata = 8'h30 + 8'(k);
         tick();
      end
      want = 1'b0;
      check("pre_reset_count", cnt_b, 3);
      check("pre_reset_head", od[1], 8'h30);
      nrst = 1'b0;
      #2;
      check("mid_reset_valid", ov[1], 0);
      check("mid_reset_credit", cok[1], 1);
      check("mid_reset_count", cnt_b, 0);
      nrst = 1'b1;
      want = 1'b1; idata = 8'h77;
      tick();
      want = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("post_reset_not_yet", ov[1], 0);
      tick();
      check("post_reset_valid", ov[1], 1);
      check("post_reset_data", od[1], 8'h77);
      check("post_reset_errs", errs(1), 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
